// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_RANGE   = 2'b01;
    localparam logic [1:0] FAULT_ALIGN   = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b11;

    localparam logic [31:0] TEXT_BASE = 32'h00400000;
    localparam logic [31:0] DATA_BASE = 32'h10010000;

    // Addresses below base wrap to huge offsets, so one unsigned compare covers both ends.
    function automatic logic [1:0] fault_cause(
        input logic        rd,
        input logic        wr,
        input logic [31:0] addr,
        input logic [3:0]  enable,
        input logic [31:0] base,
        input logic [31:0] span
    );
        logic [31:0] offset;
        offset = addr - base;
        if (rd && wr)
            return FAULT_ILLEGAL;
        if (addr[1:0] != 2'b00)
            return FAULT_ALIGN;
        if (offset >= span)
            return FAULT_RANGE;
        if (wr && enable == 4'b0000)
            return FAULT_ILLEGAL;
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Word-wide RAM with per-byte write enables and registered read; contents are not reset.
module data_memory_array
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned INDEX_BITS  = 10
) (
    input  logic                  clock,
    input  logic                  write_enable,
    input  logic [3:0]            byte_enable,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        for (int unsigned lane = 0; lane < 4; lane++) begin
            if (write_enable && byte_enable[lane])
                mem[index][8*lane +: 8] <= write_data[8*lane +: 8];
        end
        read_data <= mem[index];
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: .data segment word RAM behind a fixed wait-state handshake,
// reporting range, alignment and illegal-op faults.
module data_memory_responder
    import data_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DATA_BASE,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [31:0] dataMemAddress,
    input  logic        dataMemRead,
    input  logic        dataMemWrite,
    input  logic [31:0] dataWriteValue,
    input  logic [3:0]  dataByteEnable,
    output logic [31:0] dataReadValue,
    output logic        dataReady,
    output logic        dataFault,
    output logic [1:0]  faultCause,
    output logic [31:0] faultAddress
);

    localparam int unsigned INDEX_BITS = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN       = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LAST_WAIT  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t                 state, next_state;
    logic [3:0]             wait_count;
    logic [31:0]            held_address, held_data;
    logic [3:0]             held_enable;
    logic                   held_read, held_write;
    logic [31:0]            req_address, req_data;
    logic [3:0]             req_enable;
    logic                   req_read, req_write;
    logic [1:0]             req_cause;
    logic                   entering_resp;
    logic                   ram_write;
    logic [INDEX_BITS-1:0]  ram_index;
    logic [31:0]            ram_data;
    logic                   read_response;

    // In IDLE the live inputs drive decode so a zero-wait request can reach the RAM on its accept edge.
    always_comb begin
        if (state == IDLE) begin
            req_address = dataMemAddress;
            req_data    = dataWriteValue;
            req_enable  = dataByteEnable;
            req_read    = dataMemRead;
            req_write   = dataMemWrite;
        end else begin
            req_address = held_address;
            req_data    = held_data;
            req_enable  = held_enable;
            req_read    = held_read;
            req_write   = held_write;
        end
    end

    assign req_cause     = fault_cause(req_read, req_write, req_address, req_enable, BASE_ADDR, SPAN);
    assign ram_index     = INDEX_BITS'((req_address - BASE_ADDR) >> 2);
    assign entering_resp = (next_state == RESP);
    assign ram_write     = entering_resp && req_write && (req_cause == FAULT_NONE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (dataMemRead || dataMemWrite)
                      next_state = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT: if (wait_count == LAST_WAIT)
                      next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            wait_count   <= '0;
            held_address <= '0;
            held_data    <= '0;
            held_enable  <= '0;
            held_read    <= 1'b0;
            held_write   <= 1'b0;
        end else begin
            state      <= next_state;
            wait_count <= (state == WAIT) ? wait_count + 4'd1 : '0;
            if (state == IDLE && (dataMemRead || dataMemWrite)) begin
                held_address <= dataMemAddress;
                held_data    <= dataWriteValue;
                held_enable  <= dataByteEnable;
                held_read    <= dataMemRead;
                held_write   <= dataMemWrite;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            dataReady     <= 1'b0;
            dataFault     <= 1'b0;
            faultCause    <= FAULT_NONE;
            faultAddress  <= '0;
            read_response <= 1'b0;
        end else begin
            dataReady     <= entering_resp;
            dataFault     <= entering_resp && (req_cause != FAULT_NONE);
            faultCause    <= entering_resp ? req_cause : FAULT_NONE;
            read_response <= entering_resp && req_read && (req_cause == FAULT_NONE);
            if (entering_resp && req_cause != FAULT_NONE)
                faultAddress <= req_address;
        end
    end

    assign dataReadValue = read_response ? ram_data : '0;

    data_memory_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INDEX_BITS  (INDEX_BITS)
    ) u_array (
        .clock        (clock),
        .write_enable (ram_write),
        .byte_enable  (req_enable),
        .index        (ram_index),
        .write_data   (req_data),
        .read_data    (ram_data)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: one instance with two wait states, one with none.
module tb_data_memory_responder;

    localparam logic [31:0] BASE  = 32'h10010000;
    localparam int          DEPTH = 1024;

    typedef struct {
        int          due;
        logic        fault;
        logic [1:0]  cause;
        logic        chk_data;
        logic [31:0] data;
        logic [31:0] fa;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetN;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [31:0] faddr [2];
    logic        rd [2];
    logic        wr [2];
    logic        rdy [2];
    logic        flt [2];
    logic [3:0]  be [2];
    logic [1:0]  cause [2];

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit   [31:0] mem_m [2][DEPTH];
    logic [31:0] fa_m [2];
    bit          pend_fa [2];
    logic [31:0] pend_fa_val [2];
    exp_t        sb0[$];
    exp_t        sb1[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    data_memory_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut_ws2 (
        .clock(clock), .resetN(resetN), .dataMemAddress(addr[0]), .dataMemRead(rd[0]),
        .dataMemWrite(wr[0]), .dataWriteValue(wdata[0]), .dataByteEnable(be[0]),
        .dataReadValue(rdata[0]), .dataReady(rdy[0]), .dataFault(flt[0]),
        .faultCause(cause[0]), .faultAddress(faddr[0]));

    data_memory_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_ws0 (
        .clock(clock), .resetN(resetN), .dataMemAddress(addr[1]), .dataMemRead(rd[1]),
        .dataMemWrite(wr[1]), .dataWriteValue(wdata[1]), .dataByteEnable(be[1]),
        .dataReadValue(rdata[1]), .dataReady(rdy[1]), .dataFault(flt[1]),
        .faultCause(cause[1]), .faultAddress(faddr[1]));

    function automatic int ws_of(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%h required=%h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    function automatic int sb_size(int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic sb_push(int d, exp_t e);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    function automatic exp_t sb_pop(int d);
        if (d == 0) return sb0.pop_front();
        return sb1.pop_front();
    endfunction

    function automatic int sb_front_due(int d);
        return (d == 0) ? sb0[0].due : sb1[0].due;
    endfunction

    // Reference classification straight from the address map, in wide arithmetic.
    function automatic logic [1:0] expect_cause(logic r, logic w, logic [31:0] a, logic [3:0] b);
        longint unsigned la, lo, hi;
        la = a;
        lo = BASE;
        hi = longint'(BASE) + 4 * DEPTH;
        if (r && w)              return 2'b11;
        if (a % 4 != 0)          return 2'b10;
        if (la < lo || la >= hi) return 2'b01;
        if (w && b == 4'b0000)   return 2'b11;
        return 2'b00;
    endfunction

    task automatic wait_ready(int d);
        bit got;
        got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clock);
            if (rdy[d]) got = 1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout dut%0d actual=no_ready required=ready", d);
        end
    endtask

    task automatic issue(int d, logic r, logic w, logic [31:0] a, logic [31:0] dv,
                         logic [3:0] b, bit hold);
        exp_t        e, e2;
        logic [1:0]  cz;
        int          word;
        @(negedge clock);
        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = dv; be[d] = b;
        cz         = expect_cause(r, w, a, b);
        e.due      = cyc + 1 + ws_of(d);
        e.fault    = (cz != 2'b00);
        e.cause    = cz;
        e.chk_data = r || e.fault;
        e.data     = '0;
        if (e.fault) begin
            fa_m[d] = a;
        end else begin
            word = int'((a - BASE) / 4);
            if (r) e.data = mem_m[d][word];
            else
                for (int i = 0; i < 4; i++)
                    if (b[i]) mem_m[d][word][8*i +: 8] = dv[8*i +: 8];
        end
        e.fa = fa_m[d];
        sb_push(d, e);
        if (hold) begin
            e2     = e;
            e2.due = e.due + 2 + ws_of(d);
            sb_push(d, e2);
        end
        wait_ready(d);
        if (hold) wait_ready(d);
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    task automatic mon(int d);
        exp_t e;
        if (rdy[d]) begin
            if (sb_size(d) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready dut%0d actual=1 required=0 (cycle %0d)", d, cyc);
            end else begin
                e = sb_pop(d);
                chk("latency_cycle", d, cyc, e.due);
                chk("data_fault", d, {31'd0, flt[d]}, {31'd0, e.fault});
                chk("fault_cause", d, {30'd0, cause[d]}, {30'd0, e.cause});
                if (e.chk_data) chk("read_value", d, rdata[d], e.data);
                pend_fa[d]     = 1;
                pend_fa_val[d] = e.fa;
            end
        end else begin
            if (pend_fa[d]) begin
                chk("fault_address", d, faddr[d], pend_fa_val[d]);
                pend_fa[d] = 0;
            end
            if (sb_size(d) > 0 && cyc > sb_front_due(d)) begin
                e = sb_pop(d);
                checks++;
                failures++;
                $display("FAIL missing_ready dut%0d actual=none required=cycle_%0d", d, e.due);
            end
        end
    endtask

    always @(negedge clock) begin
        if (resetN)
            for (int d = 0; d < 2; d++) mon(d);
    end

    task automatic check_cleared(string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_ready"}, d, {31'd0, rdy[d]}, 32'd0);
            chk({tag, "_fault"}, d, {31'd0, flt[d]}, 32'd0);
            chk({tag, "_cause"}, d, {30'd0, cause[d]}, 32'd0);
            chk({tag, "_fault_address"}, d, faddr[d], 32'd0);
            chk({tag, "_read_value"}, d, rdata[d], 32'd0);
        end
    endtask

    task automatic random_op(int d);
        logic [31:0] a;
        logic        r, w;
        int          k;
        k = $urandom_range(0, 11);
        case (k)
            0, 1, 2, 3, 4, 5: a = BASE + 4 * $urandom_range(0, DEPTH - 1);
            6:       a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
            7:       a = BASE - 4 * $urandom_range(1, 4);
            8:       a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
            9:       a = BASE + 4 * (DEPTH - 1);
            10:      a = BASE;
            default: a = $urandom;
        endcase
        k = $urandom_range(0, 9);
        r = (k <= 4) || (k == 9);
        w = (k >= 5);
        issue(d, r, w, a, $urandom, 4'($urandom_range(0, 15)), 0);
    endtask

    initial begin
        int last_rc;
        resetN = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 0; wr[d] = 0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
            fa_m[d] = '0; pend_fa[d] = 0;
        end
        repeat (3) @(negedge clock);
        check_cleared("reset");
        resetN = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < DEPTH; w++)
                issue(d, 0, 1, BASE + 4 * w, $urandom, 4'hF, 0);

        for (int d = 0; d < 2; d++) begin
            issue(d, 0, 1, 32'h10010004, 32'hDEADBEEF, 4'hF, 0);
            issue(d, 1, 0, 32'h10010004, '0, 4'hF, 0);
            issue(d, 0, 1, 32'h10010008, 32'h11223344, 4'hF, 0);
            issue(d, 0, 1, 32'h10010008, 32'hAABBCCDD, 4'b0101, 0);
            issue(d, 1, 0, 32'h10010008, '0, 4'hF, 0);
            issue(d, 1, 0, 32'h1001000F, '0, 4'hF, 0);
            issue(d, 1, 0, 32'h10011000, '0, 4'hF, 0);
            issue(d, 1, 0, 32'h1000FFFC, '0, 4'hF, 0);
            issue(d, 1, 0, 32'h10010FFC, '0, 4'hF, 0);
            issue(d, 1, 1, 32'h10010000, 32'h0BADF00D, 4'hF, 0);
            issue(d, 1, 0, 32'h10010000, '0, 4'hF, 0);
            issue(d, 0, 1, 32'h10010020, 32'h12345678, 4'h0, 0);
            issue(d, 1, 0, 32'h10010020, '0, 4'hF, 0);
        end
        chk("model_lane_merge", 0, mem_m[0][2], 32'h11BB33DD);

        // Reset during the wait states of a write: nothing may commit or respond.
        @(negedge clock);
        rd[0] = 0; wr[0] = 1; addr[0] = 32'h10010010; wdata[0] = 32'hFFFF0000; be[0] = 4'hF;
        @(negedge clock);
        resetN = 1'b0;
        #1;
        check_cleared("midop_reset");
        rd[0] = 0; wr[0] = 0;
        fa_m[0] = '0; fa_m[1] = '0;
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        issue(0, 1, 0, 32'h10010010, '0, 4'hF, 0);

        for (int i = 0; i < 6; i++) begin
            issue(1, 1, 0, BASE + 4 * i, '0, 4'hF, 0);
            if (i > 0) chk("back_to_back_spacing", 1, cyc - last_rc, 32'd2);
            last_rc = cyc;
        end
        issue(1, 1, 0, 32'h10010018, '0, 4'hF, 1);
        issue(1, 0, 1, 32'h1001001C, 32'hCAFE0001, 4'hF, 1);
        issue(1, 1, 0, 32'h1001001C, '0, 4'hF, 0);

        for (int i = 0; i < 300; i++) begin
            random_op(0);
            random_op(1);
        end

        repeat (4) @(negedge clock);
        for (int d = 0; d < 2; d++)
            chk("scoreboard_drained", d, sb_size(d), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
